mext_issue_ctrl: RTL

//  EX-stage initiator for the multi-cycle mul/div unit: decodes RV32M funct3 and launches the unit.

---
 rtl/mext_pkg.sv | 29 ++
 rtl/mext_issue_ctrl_if.sv | 31 +++
 rtl/mext_result_fmt.sv | 24 ++
 rtl/mext_issue_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mext_pkg.sv
// Shared encodings for the RV32M issue controller: funct3 codes, mul/div unit ops, FSM states.
package mext_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] OP_MUL_S = 2'b00;
  localparam logic [1:0] OP_MUL_U = 2'b01;
  localparam logic [1:0] OP_DIV_S = 2'b10;
  localparam logic [1:0] OP_DIV_U = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // MULHSU runs as an unsigned multiply and is corrected afterwards.
  function automatic logic [1:0] f3_to_op(input logic [2:0] f3);
    return f3[2] ? {1'b1, f3[0]} : {1'b0, f3[1]};
  endfunction

endpackage

// File: rtl/mext_issue_ctrl_if.sv
// Pipeline-side request/response and mul/div unit signals of the M-extension issue controller.
interface mext_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             flush;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic             mc_reset;
  logic             mc_start;
  logic [1:0]       mc_op;
  logic [WIDTH-1:0] mc_operand1;
  logic [WIDTH-1:0] mc_operand2;
  logic [WIDTH-1:0] mc_result1;
  logic [WIDTH-1:0] mc_result2;
  logic             mc_busy;

  modport slave (
    input  req_valid, funct3, rs1_val, rs2_val, flush, mc_result1, mc_result2, mc_busy,
    output stall, result_valid, result, mc_reset, mc_start, mc_op, mc_operand1, mc_operand2
  );

  modport master (
    output req_valid, funct3, rs1_val, rs2_val, flush, mc_result1, mc_result2, mc_busy,
    input  stall, result_valid, result, mc_reset, mc_start, mc_op, mc_operand1, mc_operand2
  );
endinterface

// File: rtl/mext_result_fmt.sv
// Picks the rd word out of the raw unit outputs; MULHSU high word is fixed up modulo 2^WIDTH.
module mext_result_fmt
  import mext_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] raw1_i,
  input  logic [WIDTH-1:0] raw2_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = raw2_i;
    case (funct3_i)
      F3_MUL, F3_DIV, F3_DIVU: result_o = raw1_i;
      F3_MULHSU:               result_o = raw2_i - (a_i[WIDTH-1] ? b_i : '0);
      default:                 result_o = raw2_i;
    endcase
  end

endmodule

// File: rtl/mext_issue_ctrl.sv
// EX-stage launcher for the multi-cycle mul/div unit: stalls until the result returns,
// short-circuits div-by-zero / signed overflow and reuses the last computed raw words.
module mext_issue_ctrl
  import mext_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit ENABLE_CACHE = 1'b1
) (
  input logic CLK,
  input logic RESET,
  mext_issue_ctrl_if.slave io
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] raw1_q, raw1_d, raw2_q, raw2_d;
  logic             cvld_q, cvld_d;
  logic [WIDTH-1:0] key_a_q, key_a_d, key_b_q, key_b_d;
  logic [1:0]       key_op_q, key_op_d;
  logic [WIDTH-1:0] c1_q, c1_d, c2_q, c2_d;

  logic [1:0]       req_op;
  logic             byp_zero, byp_ovf, hit;
  logic [WIDTH-1:0] fmt_res;

  assign req_op   = f3_to_op(io.funct3);
  assign byp_zero = io.funct3[2] && (io.rs2_val == '0);
  assign byp_ovf  = (req_op == OP_DIV_S) && (io.rs1_val == MIN_VAL) && (io.rs2_val == '1);
  // Key holds the unit op, not funct3, so e.g. DIV/REM share one computation.
  assign hit      = ENABLE_CACHE && cvld_q && (key_a_q == io.rs1_val) &&
                    (key_b_q == io.rs2_val) && (key_op_q == req_op);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    f3_d     = f3_q;
    op_d     = op_q;
    raw1_d   = raw1_q;
    raw2_d   = raw2_q;
    cvld_d   = cvld_q;
    key_a_d  = key_a_q;
    key_b_d  = key_b_q;
    key_op_d = key_op_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    case (state_q)
      ST_IDLE: begin
        if (io.req_valid && !io.flush) begin
          a_d  = io.rs1_val;
          b_d  = io.rs2_val;
          f3_d = io.funct3;
          op_d = req_op;
          if (byp_zero) begin
            raw1_d  = '1;
            raw2_d  = io.rs1_val;
            state_d = ST_RESP;
          end else if (byp_ovf) begin
            raw1_d  = MIN_VAL;
            raw2_d  = '0;
            state_d = ST_RESP;
          end else if (hit) begin
            raw1_d  = c1_q;
            raw2_d  = c2_q;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = io.flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (io.flush) begin
          state_d = io.mc_busy ? ST_DRAIN : ST_IDLE;
        end else if (!io.mc_busy) begin
          raw1_d   = io.mc_result1;
          raw2_d   = io.mc_result2;
          key_a_d  = a_q;
          key_b_d  = b_q;
          key_op_d = op_q;
          c1_d     = io.mc_result1;
          c2_d     = io.mc_result2;
          cvld_d   = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_DRAIN: begin
        if (!io.mc_busy) begin
          cvld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      op_q     <= '0;
      raw1_q   <= '0;
      raw2_q   <= '0;
      cvld_q   <= 1'b0;
      key_a_q  <= '0;
      key_b_q  <= '0;
      key_op_q <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      op_q     <= op_d;
      raw1_q   <= raw1_d;
      raw2_q   <= raw2_d;
      cvld_q   <= cvld_d;
      key_a_q  <= key_a_d;
      key_b_q  <= key_b_d;
      key_op_q <= key_op_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
    end
  end

  mext_result_fmt #(.WIDTH(WIDTH)) u_fmt (
    .funct3_i (f3_q),
    .raw1_i   (raw1_q),
    .raw2_i   (raw2_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (fmt_res)
  );

  assign io.stall        = io.req_valid && (((state_q != ST_RESP) && !io.flush) || (state_q == ST_DRAIN));
  assign io.result_valid = (state_q == ST_RESP) && !io.flush;
  assign io.result       = (state_q == ST_RESP) ? fmt_res : '0;
  assign io.mc_reset     = ~RESET;
  assign io.mc_start     = (state_q == ST_ISSUE);
  assign io.mc_op        = op_q;
  assign io.mc_operand1  = a_q;
  assign io.mc_operand2  = b_q;

endmodule
